// File: rtl/minhash_bottomk_sorter_if.sv
// Handshake bundle for minhash_bottomk_sorter.
//   in_*  : one (signature, index) beat per in_valid && in_ready; in_last ends a sequence.
//   out_* : K ranked slots streamed under out_valid/out_ready after a sequence ends.
// Modports: master = upstream/downstream side (drives beats and out_ready),
//           slave  = the sorter itself.
interface minhash_bottomk_sorter_if #(
  parameter int SIGNATURE_WIDTH = 32,
  parameter int INDEX_WIDTH     = 10,
  parameter int RANK_WIDTH      = 3
);
  logic                       in_valid;
  logic                       in_ready;
  logic [SIGNATURE_WIDTH-1:0] in_signature;
  logic [INDEX_WIDTH-1:0]     in_index;
  logic                       in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic [RANK_WIDTH-1:0]      out_rank;
  logic [SIGNATURE_WIDTH-1:0] out_signature;
  logic [INDEX_WIDTH-1:0]     out_index;
  logic                       out_occupied;
  logic                       out_last;
  logic [RANK_WIDTH:0]        out_count;

  modport master (
    output in_valid, in_signature, in_index, in_last, out_ready,
    input  in_ready, out_valid, out_rank, out_signature, out_index,
           out_occupied, out_last, out_count
  );

  modport slave (
    input  in_valid, in_signature, in_index, in_last, out_ready,
    output in_ready, out_valid, out_rank, out_signature, out_index,
           out_occupied, out_last, out_count
  );
endinterface

// File: rtl/minhash_bottomk_sorter.sv
// Bottom-K selector for the MinHash signature path.
// Keeps the K smallest signatures seen in a sequence, sorted ascending in an
// insertion-shift register array, then streams all K slots out in rank order.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : minhash_bottomk_sorter_if.slave (input beats, ranked output slots)
module minhash_bottomk_sorter #(
  parameter int SIGNATURE_WIDTH = 32,
  parameter int INDEX_WIDTH     = 10,
  parameter int K               = 8,
  parameter int RANK_WIDTH      = 3,
  parameter int DEDUP           = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  minhash_bottomk_sorter_if.slave     bus
);

  localparam logic [RANK_WIDTH-1:0] LAST_RANK  = RANK_WIDTH'(K - 1);
  localparam logic [RANK_WIDTH:0]   FULL_COUNT = (RANK_WIDTH + 1)'(K);

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t state_reg, state_next;

  logic [SIGNATURE_WIDTH-1:0] sig_reg [K];
  logic [INDEX_WIDTH-1:0]     idx_reg [K];
  logic                       occ_reg [K];
  logic [RANK_WIDTH-1:0]      rank_reg;
  logic [RANK_WIDTH:0]        count_reg;

  // Candidate array contents if the current beat were inserted.
  logic [SIGNATURE_WIDTH-1:0] sig_ins [K];
  logic [INDEX_WIDTH-1:0]     idx_ins [K];
  logic                       occ_ins [K];

  // le_vec[i]: slot i is occupied and sorts at or before the incoming beat.
  // Because occupied slots are contiguous and ascending, le_vec is a prefix
  // of ones and its length is the insert position p.
  logic [K-1:0] le_vec;
  logic [K-1:0] eq_vec;

  logic accept;
  logic duplicate;
  logic insert;
  logic xfer;
  logic last_xfer;

  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_slot
      assign le_vec[gi] = occ_reg[gi] && (sig_reg[gi] <= bus.in_signature);
      assign eq_vec[gi] = occ_reg[gi] && (sig_reg[gi] == bus.in_signature);

      if (gi == 0) begin : g_head
        assign sig_ins[gi] = le_vec[gi] ? sig_reg[gi] : bus.in_signature;
        assign idx_ins[gi] = le_vec[gi] ? idx_reg[gi] : bus.in_index;
        assign occ_ins[gi] = le_vec[gi] ? occ_reg[gi] : 1'b1;
      end else begin : g_body
        // Slot at the prefix boundary takes the new entry; slots past it
        // take their lower neighbour (shift up); slots before it hold.
        assign sig_ins[gi] = le_vec[gi]     ? sig_reg[gi] :
                             le_vec[gi-1]   ? bus.in_signature : sig_reg[gi-1];
        assign idx_ins[gi] = le_vec[gi]     ? idx_reg[gi] :
                             le_vec[gi-1]   ? bus.in_index : idx_reg[gi-1];
        assign occ_ins[gi] = le_vec[gi]     ? occ_reg[gi] :
                             le_vec[gi-1]   ? 1'b1 : occ_reg[gi-1];
      end
    end
  endgenerate

  assign accept    = (state_reg == COLLECT) && bus.in_valid;
  assign duplicate = (DEDUP != 0) && (|eq_vec);
  // le_vec[K-1] set means p == K: the beat is larger than every kept entry.
  assign insert    = accept && !duplicate && !le_vec[K-1];
  assign xfer      = (state_reg == DRAIN) && bus.out_ready;
  assign last_xfer = xfer && (rank_reg == LAST_RANK);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (accept && bus.in_last) state_next = DRAIN;
      DRAIN:   if (last_xfer)             state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // Slot array, rank counter and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) begin
        sig_reg[i] <= '0;
        idx_reg[i] <= '0;
        occ_reg[i] <= 1'b0;
      end
      rank_reg  <= '0;
      count_reg <= '0;
    end else if (last_xfer) begin
      for (int i = 0; i < K; i++) begin
        sig_reg[i] <= '0;
        idx_reg[i] <= '0;
        occ_reg[i] <= 1'b0;
      end
      rank_reg  <= '0;
      count_reg <= '0;
    end else if (xfer) begin
      rank_reg <= rank_reg + RANK_WIDTH'(1);
    end else if (insert) begin
      for (int i = 0; i < K; i++) begin
        sig_reg[i] <= sig_ins[i];
        idx_reg[i] <= idx_ins[i];
        occ_reg[i] <= occ_ins[i];
      end
      if (count_reg != FULL_COUNT) begin
        count_reg <= count_reg + (RANK_WIDTH + 1)'(1);
      end
    end
  end

  // Outputs: in DRAIN the slot at the rank counter is presented directly, so
  // fields are stable for as long as out_ready is held low.
  always_comb begin
    bus.in_ready      = (state_reg == COLLECT);
    bus.out_valid     = 1'b0;
    bus.out_rank      = '0;
    bus.out_signature = '0;
    bus.out_index     = '0;
    bus.out_occupied  = 1'b0;
    bus.out_last      = 1'b0;
    bus.out_count     = count_reg;
    if (state_reg == DRAIN) begin
      bus.out_valid     = 1'b1;
      bus.out_rank      = rank_reg;
      bus.out_signature = sig_reg[rank_reg];
      bus.out_index     = idx_reg[rank_reg];
      bus.out_occupied  = occ_reg[rank_reg];
      bus.out_last      = (rank_reg == LAST_RANK);
    end
  end

endmodule

// File: tb/tb_minhash_bottomk_sorter.sv
// Drives a DEDUP=1 and a DEDUP=0 sorter (K=4) with identical stimulus and
// checks each against a queue-based bottom-K model through a scoreboard.
module tb_minhash_bottomk_sorter;
  localparam int SW = 32;
  localparam int IW = 10;
  localparam int K  = 4;
  localparam int RW = 2;

  typedef struct {
    logic [SW-1:0] sig;
    logic [IW-1:0] idx;
  } ent_t;
  typedef ent_t ent_q_t[$];

  typedef struct {
    logic [RW-1:0] rank;
    logic [SW-1:0] sig;
    logic [IW-1:0] idx;
    logic          occ;
    logic          last;
    logic [RW:0]   count;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [SW-1:0] in_signature = '0;
  logic [IW-1:0] in_index = '0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  ent_q_t model_d, model_n;
  exp_t   exp_q_d[$], exp_q_n[$];

  always #5 clk = ~clk;

  minhash_bottomk_sorter_if #(.SIGNATURE_WIDTH(SW), .INDEX_WIDTH(IW), .RANK_WIDTH(RW)) bus_d ();
  minhash_bottomk_sorter_if #(.SIGNATURE_WIDTH(SW), .INDEX_WIDTH(IW), .RANK_WIDTH(RW)) bus_n ();

  assign bus_d.in_valid = in_valid;
  assign bus_d.in_signature = in_signature;
  assign bus_d.in_index = in_index;
  assign bus_d.in_last = in_last;
  assign bus_d.out_ready = out_ready;
  assign bus_n.in_valid = in_valid;
  assign bus_n.in_signature = in_signature;
  assign bus_n.in_index = in_index;
  assign bus_n.in_last = in_last;
  assign bus_n.out_ready = out_ready;

  minhash_bottomk_sorter #(.SIGNATURE_WIDTH(SW), .INDEX_WIDTH(IW), .K(K), .RANK_WIDTH(RW), .DEDUP(1))
    dut_d (.clk(clk), .rst_n(rst_n), .bus(bus_d));
  minhash_bottomk_sorter #(.SIGNATURE_WIDTH(SW), .INDEX_WIDTH(IW), .K(K), .RANK_WIDTH(RW), .DEDUP(0))
    dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: keep a sorted list; new entry goes after all entries <= it.
  function automatic ent_q_t model_insert(input ent_q_t q, input logic [SW-1:0] sig,
                                          input logic [IW-1:0] idx, input bit dedup);
    ent_q_t r = q;
    ent_t e;
    int p = 0;
    e.sig = sig;
    e.idx = idx;
    if (dedup) begin
      foreach (r[i]) if (r[i].sig == sig) return r;
    end
    foreach (r[i]) if (r[i].sig <= sig) p++;
    if (p >= K) return r;
    r.insert(p, e);
    if (r.size() > K) void'(r.pop_back());
    return r;
  endfunction

  task automatic push_expect(input ent_q_t q, input bit dedup);
    exp_t e;
    for (int r = 0; r < K; r++) begin
      e.rank  = RW'(r);
      e.occ   = (r < q.size());
      e.sig   = e.occ ? q[r].sig : '0;
      e.idx   = e.occ ? q[r].idx : '0;
      e.last  = (r == K - 1);
      e.count = (RW + 1)'(q.size());
      if (dedup) exp_q_d.push_back(e);
      else       exp_q_n.push_back(e);
    end
  endtask

  task automatic check_beat(input bit dedup, input logic [RW-1:0] rank, input logic [SW-1:0] sig,
                            input logic [IW-1:0] idx, input logic occ, input logic last,
                            input logic [RW:0] count);
    exp_t e;
    checks++;
    if ((dedup ? exp_q_d.size() : exp_q_n.size()) == 0) begin
      errors++;
      $display("FAIL beat dedup=%0d unexpected transfer rank=%0d sig=%0h", dedup, rank, sig);
    end else begin
      e = dedup ? exp_q_d.pop_front() : exp_q_n.pop_front();
      if ({rank, sig, idx, occ, last, count} !== {e.rank, e.sig, e.idx, e.occ, e.last, e.count}) begin
        errors++;
        $display("FAIL beat dedup=%0d actual rank=%0d sig=%0h idx=%0d occ=%0d last=%0d cnt=%0d required rank=%0d sig=%0h idx=%0d occ=%0d last=%0d cnt=%0d",
                 dedup, rank, sig, idx, occ, last, count, e.rank, e.sig, e.idx, e.occ, e.last, e.count);
      end else begin
        $display("beat dedup=%0d rank=%0d sig=%0h idx=%0d occ=%0d last=%0d cnt=%0d ok",
                 dedup, rank, sig, idx, occ, last, count);
      end
    end
  endtask

  // Monitors: compare every output transfer against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus_d.out_valid && bus_d.out_ready)
      check_beat(1'b1, bus_d.out_rank, bus_d.out_signature, bus_d.out_index,
                 bus_d.out_occupied, bus_d.out_last, bus_d.out_count);
  end

  always @(negedge clk) begin
    if (rst_n && bus_n.out_valid && bus_n.out_ready)
      check_beat(1'b0, bus_n.out_rank, bus_n.out_signature, bus_n.out_index,
                 bus_n.out_occupied, bus_n.out_last, bus_n.out_count);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [SW-1:0] sig, input logic [IW-1:0] idx, input bit last);
    in_valid = 1'b1;
    in_signature = sig;
    in_index = idx;
    in_last = last;
    @(negedge clk);
    cmp("in_ready_collect_d", {63'd0, bus_d.in_ready}, 64'd1);
    cmp("in_ready_collect_n", {63'd0, bus_n.in_ready}, 64'd1);
    @(posedge clk);
    model_d = model_insert(model_d, sig, idx, 1'b1);
    model_n = model_insert(model_n, sig, idx, 1'b0);
    if (last) begin
      push_expect(model_d, 1'b1);
      push_expect(model_n, 1'b0);
      model_d.delete();
      model_n.delete();
    end
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain(input int pct);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 200) begin
      out_ready = ($urandom_range(0, 99) < pct);
      @(negedge clk);
      if (bus_d.out_valid && out_ready && bus_d.out_last) done = 1'b1;
      tick();
      n++;
    end
    out_ready = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=no_last required=last_within_200");
    end
    cmp("in_ready_after_drain_d", {63'd0, bus_d.in_ready}, 64'd1);
    cmp("in_ready_after_drain_n", {63'd0, bus_n.in_ready}, 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SW-1:0] s;
    int len;

    // Reset state
    #2;
    cmp("rst_in_ready", {63'd0, bus_d.in_ready}, 64'd1);
    cmp("rst_out_valid", {63'd0, bus_d.out_valid}, 64'd0);
    cmp("rst_out_rank", {62'd0, bus_d.out_rank}, 64'd0);
    cmp("rst_out_sig", {32'd0, bus_d.out_signature}, 64'd0);
    cmp("rst_out_occ_last", {62'd0, bus_d.out_occupied, bus_d.out_last}, 64'd0);
    cmp("rst_out_count", {61'd0, bus_n.out_count}, 64'd0);
    #10 rst_n = 1'b1;
    tick();

    // Ascending fill, 50 dropped at p==K with in_last
    for (int v = 10; v <= 50; v += 10) send(SW'(v), IW'(v), v == 50);
    drain(100);

    // Descending eviction, back-to-back
    for (int v = 90; v >= 40; v -= 10) send(SW'(v), IW'(v), v == 40);
    drain(100);

    // Duplicates
    send(32'd5, 10'd1, 1'b0);
    send(32'd5, 10'd2, 1'b0);
    send(32'd3, 10'd3, 1'b0);
    send(32'd5, 10'd4, 1'b1);
    drain(100);

    // All-ones signature is storable
    send(32'hFFFF_FFFF, 10'd9, 1'b1);
    drain(100);

    // In_last beat dropped by dedup still ends the sequence
    send(32'd9, 10'd1, 1'b0);
    send(32'd9, 10'd2, 1'b1);
    drain(60);

    // Backpressure at rank 1
    send(32'd1, 10'd1, 1'b0);
    send(32'd2, 10'd2, 1'b0);
    send(32'd3, 10'd3, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cmp("bp_rank", {62'd0, bus_d.out_rank}, 64'd1);
      cmp("bp_sig_idx", {22'd0, bus_d.out_signature, bus_d.out_index}, {22'd0, 32'd2, 10'd2});
      cmp("bp_valid_ready", {62'd0, bus_d.out_valid, bus_d.in_ready}, 64'd2);
      tick();
    end
    drain(100);

    // Reset mid-DRAIN at rank 2
    send(32'd11, 10'd1, 1'b0);
    send(32'd12, 10'd2, 1'b0);
    send(32'd13, 10'd3, 1'b1);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    cmp("pre_rst_rank", {62'd0, bus_d.out_rank}, 64'd2);
    #2 rst_n = 1'b0;
    #1;
    cmp("async_rst_out_valid", {62'd0, bus_d.out_valid, bus_n.out_valid}, 64'd0);
    cmp("async_rst_in_ready", {62'd0, bus_d.in_ready, bus_n.in_ready}, 64'd3);
    cmp("async_rst_count", {61'd0, bus_d.out_count}, 64'd0);
    exp_q_d.delete();
    exp_q_n.delete();
    model_d.delete();
    model_n.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(32'd7, 10'd7, 1'b0);
    send(32'd8, 10'd8, 1'b1);
    drain(100);

    // Randomized sequences with duplicates, extremes and gaps
    for (int seq = 0; seq < 25; seq++) begin
      len = $urandom_range(1, 10);
      for (int b = 0; b < len; b++) begin
        case ($urandom_range(0, 9))
          0: s = '0;
          1: s = 32'hFFFF_FFFF;
          2: s = $urandom;
          default: s = SW'($urandom_range(0, 20));
        endcase
        if ($urandom_range(0, 3) == 0) tick();
        send(s, IW'($urandom_range(0, 1023)), b == len - 1);
      end
      drain(70);
    end

    cmp("scoreboard_empty", {32'd0, 32'(exp_q_d.size() + exp_q_n.size())}, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
